ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative HI/LO multiply/divide unit for the EX stage. It consumes the ALUOp, ReadData1 and ReadData2 fields that the ID/EX register drives into EX, and it returns the EX Stall request. It executes MULT/MULTU/DIV/DIVU in 32 iterations, owns the architectural HI/LO registers, and serves MFHI/MFLO/MTHI/MTLO. It stalls only the instructions that touch HI/LO while an operation is in flight.

## Interface
Parameters (ALUOp encodings):
- OP_MFHI, 5'h10, read HI
- OP_MTHI, 5'h11, write HI
- OP_MFLO, 5'h12, read LO
- OP_MTLO, 5'h13, write LO
- OP_MULT, 5'h18, signed 32x32 multiply
- OP_MULTU, 5'h19, unsigned 32x32 multiply
- OP_DIV, 5'h1A, signed divide
- OP_DIVU, 5'h1B, unsigned divide

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op_valid  in  1  valid instruction present in EX
- alu_op  in  5  ALUOp of the EX instruction
- read_data1  in  32  rs operand (dividend / multiplicand / MTxx source)
- read_data2  in  32  rt operand (divisor / multiplier)
- ex_hold  in  1  EX held by some other source this cycle (excludes this block's stall)
- flush  in  1  kill the EX instruction this cycle
- stall  out  1  HI/LO hazard; EX must hold
- busy  out  1  iteration in progress
- hilo_rdata  out  32  HI (MFHI) or LO (MFLO); 0 for other ops

## Operation
- A HI/LO op is any of the eight encodings above.
- Start condition: accept = op_valid & alu_op ∈ {MULT, MULTU, DIV, DIVU} & !busy & !ex_hold & !flush.
- An MTHI/MTLO write occurs when op_valid & !busy & !ex_hold & !flush. It writes read_data1 into HI or LO at the clock edge.
- stall = op_valid & (HI/LO op) & busy. It is combinational from registered busy, so there is no loop through ex_hold.
- Non-HI/LO instructions never stall, even while busy.
- The accepted mul/div instruction itself is not stalled by this block.
- hilo_rdata is combinational from the HI/LO registers, selected by alu_op. It is meaningful only when stall = 0.
- State machine:
  - IDLE → CALC on accept. On entry, latch the operand magnitudes (absolute value if signed op and operand bit 31 set), the result-sign flags and the op kind, and clear the 6-bit count.
  - CALC: one iteration per cycle for count = 0..31, then → FIX.
    - Multiply: radix-2 shift-add into a 64-bit accumulator.
    - Divide: restoring shift-subtract producing a 32-bit quotient and 32-bit remainder.
  - FIX: apply signs (two's-complement negate), then write HI/LO at the edge and → IDLE.
    - MULT/MULTU: {HI,LO} = product. The product is negated if the operand signs differ (signed op only).
    - DIV/DIVU: LO = quotient, HI = remainder. The quotient is negated if the signs differ; the remainder takes the sign of the dividend.
- Divide by zero (no exception):
  - Magnitude result: quotient 32'hFFFFFFFF, remainder = |dividend|; signs are then applied per the rules above.
  - DIVU x/0: LO = FFFFFFFF, HI = x.
  - DIV -7/0: LO = 00000001, HI = FFFFFFF9.
- DIV 80000000 / FFFFFFFF: LO = 80000000 (wraps), HI = 0.
- Arithmetic is modulo 2^32 per register; there are no overflow flags.

## Timing
- Reset (asynchronous, rst_n low): state IDLE, count 0, HI = 0, LO = 0, busy = 0, stall = 0, hilo_rdata = 0, accumulators 0.
  - Reset mid-operation abandons the operation; HI/LO read 0 afterwards.
- For accept in cycle T:
  - busy = 1 in cycles T+1..T+33 (CALC T+1..T+32, FIX T+33).
  - HI/LO update at the edge ending T+33.
  - IDLE and busy = 0 in T+34.
- An MFHI/MFLO in EX during T+1..T+33 sees stall = 1. In T+34 it sees stall = 0 and the new value: 33 cycles of stall worst case.
- A second MULT/DIV arriving while busy stalls and is accepted in the first cycle busy = 0.
- flush or ex_hold in the start cycle: no accept, and state is unchanged.
  - After ex_hold releases, the same instruction is accepted exactly once.
- flush while busy has no effect; the in-flight op is committed.
- MTHI/MTLO arriving while busy stalls, then writes in the first idle cycle.
- Simultaneous flush and stall: stall follows its own equation; the instruction is discarded by the pipeline.

## Test plan
- Reset → HI = LO = 0, busy = stall = 0. MFLO yields 0.
- MULTU FFFFFFFF × FFFFFFFF, then MFHI immediately behind it:
  - stall for 33 cycles.
  - HI = FFFFFFFE, LO = 00000001.
  - busy high exactly 33 cycles.
- MULT FFFFFFFD (−3) × 7 → HI = FFFFFFFF, LO = FFFFFFEB.
- DIV:
  - DIV −7 / 2 → LO = FFFFFFFD, HI = FFFFFFFF.
  - DIVU 7 / 0 → LO = FFFFFFFF, HI = 00000007.
  - DIV 80000000 / FFFFFFFF → LO = 80000000, HI = 0.
- MULT with ex_hold high for 3 cycles then released → exactly one operation starts. Independent ADDs issued while busy show stall = 0.
- MTLO 1234 with flush → LO unchanged.
- MULT started, rst_n pulsed low at T+10 → busy = 0 immediately, HI = LO = 0.
- MTHI issued while busy stalls until T+34, then HI = operand. The MULT result is written first and then overwritten by MTHI.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide, owns HI/LO.
// Latency: accept at T, busy T+1..T+33, HI/LO written at the edge ending T+33.
// Backpressure: HI/LO ops see stall while busy; other instructions pass freely.
module ex_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [4:0]  alu_op,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    input  logic        ex_hold,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hilo_rdata
);

    localparam logic [4:0] OP_MFHI  = 5'h10;
    localparam logic [4:0] OP_MTHI  = 5'h11;
    localparam logic [4:0] OP_MFLO  = 5'h12;
    localparam logic [4:0] OP_MTLO  = 5'h13;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        busy_q, busy_d;

    logic        is_md, is_hilo, is_signed, can_go, accept;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] mul_next, div_next;
    logic        div_fits;
    logic [31:0] div_diff;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    // 10h..13h are the moves, 18h..1Bh the mul/div ops; bit0 = unsigned, bit1 = divide
    assign is_md     = (alu_op[4:2] == 3'b110);
    assign is_hilo   = is_md | (alu_op[4:2] == 3'b100);
    assign is_signed = ~alu_op[0];
    assign can_go    = op_valid & ~busy_q & ~ex_hold & ~flush;
    assign accept    = can_go & is_md;

    assign a_neg = is_signed & read_data1[31];
    assign b_neg = is_signed & read_data2[31];
    assign a_mag = a_neg ? (~read_data1 + 32'd1) : read_data1;
    assign b_mag = b_neg ? (~read_data2 + 32'd1) : read_data2;

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, dvsr_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient bits}
    assign div_fits = (acc_q[63:31] >= {1'b0, dvsr_q});
    assign div_diff = acc_q[62:31] - dvsr_q;
    assign div_next = div_fits ? {div_diff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};

    assign prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
    assign quo_fix  = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        dvsr_d    = dvsr_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        busy_d    = busy_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_CALC;
                    busy_d    = 1'b1;
                    cnt_d     = 6'd0;
                    is_div_d  = alu_op[1];
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    acc_d     = {32'd0, alu_op[1] ? a_mag : b_mag};
                    dvsr_d    = alu_op[1] ? b_mag : a_mag;
                end else if (can_go && alu_op == OP_MTHI) begin
                    hi_d = read_data1;
                end else if (can_go && alu_op == OP_MTLO) begin
                    lo_d = read_data1;
                end
            end
            S_CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            acc_q     <= 64'd0;
            dvsr_q    <= 32'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            dvsr_q    <= dvsr_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
        end
    end

    assign busy  = busy_q;
    assign stall = op_valid & is_hilo & busy_q;

    always_comb begin
        hilo_rdata = 32'd0;
        if (alu_op == OP_MFHI) begin
            hilo_rdata = hi_q;
        end else if (alu_op == OP_MFLO) begin
            hilo_rdata = lo_q;
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: driver issues instructions in program order and pushes expected MFHI/MFLO
// values from an arithmetic model; a monitor pops and compares whenever an MFxx retires.
module tb_ex_muldiv;

    localparam logic [4:0] OP_ADD   = 5'h00;
    localparam logic [4:0] OP_MFHI  = 5'h10;
    localparam logic [4:0] OP_MTHI  = 5'h11;
    localparam logic [4:0] OP_MFLO  = 5'h12;
    localparam logic [4:0] OP_MTLO  = 5'h13;
    localparam logic [4:0] OP_MULT  = 5'h18;
    localparam logic [4:0] OP_MULTU = 5'h19;
    localparam logic [4:0] OP_DIV   = 5'h1A;
    localparam logic [4:0] OP_DIVU  = 5'h1B;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [4:0]  alu_op;
    logic [31:0] read_data1, read_data2;
    logic        ex_hold, flush;
    logic        stall, busy;
    logic [31:0] hilo_rdata;

    always #5 clk = ~clk;

    ex_muldiv dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .alu_op     (alu_op),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .ex_hold    (ex_hold),
        .flush      (flush),
        .stall      (stall),
        .busy       (busy),
        .hilo_rdata (hilo_rdata)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_hi, m_lo;
    int          busy_run = 0;
    int          last_busy_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: measures busy run lengths and checks every retiring MFHI/MFLO
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                last_busy_len = busy_run;
                busy_run = 0;
            end
            if (op_valid && !flush && !ex_hold && !stall &&
                (alu_op == OP_MFHI || alu_op == OP_MFLO)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_underflow: got %08h expected nothing queued", hilo_rdata);
                end else begin
                    chk(alu_op == OP_MFHI ? "mfhi" : "mflo", hilo_rdata, exp_q.pop_front());
                end
            end
        end
    end

    // Architectural reference: HI/LO after each instruction in program order
    task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MTHI:  m_hi = a;
            OP_MTLO:  m_lo = a;
            OP_MFHI:  exp_q.push_back(m_hi);
            OP_MFLO:  exp_q.push_back(m_lo);
            OP_MULT: begin
                p = 64'(sa * sb);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    m_lo = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
                    m_hi = a;
                end else begin
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            default: ;
        endcase
    endtask

    // Presents one instruction in EX until it leaves (not stalled, not held), returns stall cycles
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit fl, output int stalls, output logic busy_seen);
        bit done;
        done = 1'b0;
        stalls = 0;
        busy_seen = 1'b0;
        if (!fl) model(op, a, b);
        op_valid = 1'b1;
        alu_op = op;
        read_data1 = a;
        read_data2 = b;
        for (int i = 0; i < hold; i++) begin
            ex_hold = 1'b1;
            @(negedge clk);
            chk("hold_no_start", {31'd0, busy}, 32'd0);
            @(posedge clk);
            #1;
        end
        ex_hold = 1'b0;
        if (fl) begin
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
            op_valid = 1'b0;
            alu_op = OP_ADD;
            return;
        end
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            busy_seen = busy;
            if (stall) stalls++;
            else done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL retire_timeout: op %02h still stalled after 200 cycles, required release", op);
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        alu_op = OP_ADD;
    endtask

    task automatic md_and_read(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int   s;
        logic bs;
        issue(op, a, b, 0, 1'b0, s, bs);
        issue(OP_MFHI, 0, 0, 0, 1'b0, s, bs);
        chk("mfhi_stall_len", 32'(s), 32'd33);
        issue(OP_MFLO, 0, 0, 0, 1'b0, s, bs);
        chk("mflo_after_stall", 32'(s), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int          s;
        logic        bs;
        logic [4:0]  ops[10];
        logic [4:0]  op;
        logic [31:0] a, b;

        ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO,
                OP_MFHI, OP_MFLO, OP_ADD, OP_DIV};
        rst_n = 1'b0;
        op_valid = 1'b0;
        alu_op = OP_ADD;
        read_data1 = 32'd0;
        read_data2 = 32'd0;
        ex_hold = 1'b0;
        flush = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(OP_MFLO, 0, 0, 0, 1'b0, s, bs);
        chk("rst_mflo_stall", 32'(s), 32'd0);
        issue(OP_MFHI, 0, 0, 0, 1'b0, s, bs);

        md_and_read(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("busy_len_multu", 32'(last_busy_len), 32'd33);
        md_and_read(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        md_and_read(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        md_and_read(OP_DIVU, 32'd7, 32'd0);
        md_and_read(OP_DIV, 32'hFFFF_FFF9, 32'd0);
        md_and_read(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

        // MULT held three cycles, then independent ADDs flow past while busy
        issue(OP_MULT, 32'd12345, 32'hFFFF_0001, 3, 1'b0, s, bs);
        for (int i = 0; i < 3; i++) begin
            issue(OP_ADD, 32'(i), 32'd1, 0, 1'b0, s, bs);
            chk("add_no_stall", 32'(s), 32'd0);
            chk("add_while_busy", {31'd0, bs}, 32'd1);
        end
        issue(OP_MFHI, 0, 0, 0, 1'b0, s, bs);
        issue(OP_MFLO, 0, 0, 0, 1'b0, s, bs);
        chk("busy_len_held_mult", 32'(last_busy_len), 32'd33);

        issue(OP_MTLO, 32'h0000_1234, 0, 0, 1'b1, s, bs);
        issue(OP_MFLO, 0, 0, 0, 1'b0, s, bs);

        // Reset in the middle of a multiply abandons it
        issue(OP_MULT, 32'd5, 32'd6, 0, 1'b0, s, bs);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midop_rst_busy", {31'd0, busy}, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(OP_MFHI, 0, 0, 0, 1'b0, s, bs);
        issue(OP_MFLO, 0, 0, 0, 1'b0, s, bs);

        issue(OP_MULT, 32'h0001_0003, 32'h0002_0005, 0, 1'b0, s, bs);
        issue(OP_MTHI, 32'hCAFE_F00D, 0, 0, 1'b0, s, bs);
        chk("mthi_stall_len", 32'(s), 32'd33);
        issue(OP_MFHI, 0, 0, 0, 1'b0, s, bs);
        issue(OP_MFLO, 0, 0, 0, 1'b0, s, bs);

        issue(OP_DIVU, 32'd1000, 32'd7, 0, 1'b0, s, bs);
        issue(OP_MULT, 32'hFFFF_FFFF, 32'd9, 0, 1'b0, s, bs);
        chk("second_md_stall", 32'(s), 32'd33);
        issue(OP_MFHI, 0, 0, 0, 1'b0, s, bs);
        issue(OP_MFLO, 0, 0, 0, 1'b0, s, bs);

        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 9)];
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: a = 32'h8000_0000;
                default: ;
            endcase
            issue(op, a, b, 0, ((op == OP_MTHI || op == OP_MTLO) && $urandom_range(0, 3) == 0),
                  s, bs);
            if ($urandom_range(0, 2) == 0) issue(OP_MFHI, 0, 0, 0, 1'b0, s, bs);
            if ($urandom_range(0, 2) == 0) issue(OP_MFLO, 0, 0, 0, 1'b0, s, bs);
        end
        issue(OP_MFHI, 0, 0, 0, 1'b0, s, bs);
        issue(OP_MFLO, 0, 0, 0, 1'b0, s, bs);

        repeat (2) @(posedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
